// File: rtl/reg_file_pkg.sv
// Shared types for the checkpointed register file.
// Holds default sizes, the address/data/slot typedefs and the restore FSM state enum.
package reg_file_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_AW       = $clog2(RF_NUM_REGS);
  localparam int RF_NUM_CKPT = 4;
  localparam int RF_SW       = (RF_NUM_CKPT > 1) ?
                               $clog2(RF_NUM_CKPT) : 1;

  typedef logic [RF_AW-1:0]     reg_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_SW-1:0]     ckpt_slot_t;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_COPY,
    RF_DONE
  } rf_state_e;

endpackage

// File: rtl/ckpt_bank.sv
// Checkpoint storage: NUM_CKPT snapshots of NUM_REGS words each.
// Ports: clk; save_en/save_slot/save_row write a full snapshot row;
//   rd_slot/rd_blk select RESTORE_PER_CYCLE consecutive words on rd_words.
// Contents are deliberately not reset.
module ckpt_bank
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH        = RF_DATA_W,
  parameter int NUM_REGS          = RF_NUM_REGS,
  parameter int NUM_CKPT          = RF_NUM_CKPT,
  parameter int RESTORE_PER_CYCLE = 8,
  localparam int AW   = $clog2(NUM_REGS),
  localparam int SW   = (NUM_CKPT > 1) ?
                        $clog2(NUM_CKPT) : 1,
  localparam int NBLK = NUM_REGS / RESTORE_PER_CYCLE,
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                                clk,
  input  logic                                save_en,
  input  logic [SW-1:0]                       save_slot,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]      save_row,
  input  logic [SW-1:0]                       rd_slot,
  input  logic [BW-1:0]                       rd_blk,
  output logic [RESTORE_PER_CYCLE*DATA_WIDTH-1:0] rd_words
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_CKPT][NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_CKPT][NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (save_en && (int'(save_slot) < NUM_CKPT)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_d[save_slot][AW'(i)] =
          save_row[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    rd_words = '0;
    for (int j = 0; j < RESTORE_PER_CYCLE; j++) begin
      idx = AW'(int'(rd_blk) * RESTORE_PER_CYCLE + j);
      rd_words[j*DATA_WIDTH +: DATA_WIDTH] =
        mem_q[rd_slot][idx];
    end
  end

endmodule

// File: rtl/ckpt_reg_file.sv
// Architectural register file with async reads, one sync write port and
// NUM_CKPT checkpoint slots restored block-by-block by a small FSM.
// Ports: clk, rst (sync, active-high); rd_en/rd_addr/rd_data read ports;
//   wr_en/wr_addr/wr_data write-back; ckpt_save(_slot), ckpt_restore(_slot)
//   requests; ckpt_valid, busy, restore_done, ckpt_err status.
// Optional: define RF_WR_BYPASS_EN for write-first read bypass.
module ckpt_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH        = RF_DATA_W,
  parameter int NUM_REGS          = RF_NUM_REGS,
  parameter int NUM_RD            = 2,
  parameter int NUM_CKPT          = RF_NUM_CKPT,
  parameter int RESTORE_PER_CYCLE = 8,
  localparam int AW = $clog2(NUM_REGS),
  localparam int SW = (NUM_CKPT > 1) ?
                      $clog2(NUM_CKPT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         ckpt_save,
  input  logic [SW-1:0]                ckpt_save_slot,
  input  logic                         ckpt_restore,
  input  logic [SW-1:0]                ckpt_restore_slot,
  output logic [NUM_CKPT-1:0]          ckpt_valid,
  output logic                         busy,
  output logic                         restore_done,
  output logic                         ckpt_err
);

  localparam int RPC  = RESTORE_PER_CYCLE;
  localparam int NBLK = NUM_REGS / RPC;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int DW   = DATA_WIDTH;

  if (NUM_REGS % RESTORE_PER_CYCLE != 0) begin : g_rpc_chk
    $error("NUM_REGS must be a multiple of RESTORE_PER_CYCLE");
  end

  rf_state_e state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic err_q, err_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  logic idle_like;
  logic slot_ok;
  logic restore_ok;
  logic save_ok;
  logic wr_ok;
  logic [NUM_REGS*DW-1:0] save_row;
  logic [RPC*DW-1:0] blk_words;

  // DONE behaves exactly like IDLE for new requests and writes.
  assign idle_like  = (state_q != RF_COPY);
  assign slot_ok    = (int'(ckpt_restore_slot) < NUM_CKPT) &&
                      valid_q[ckpt_restore_slot];
  assign restore_ok = idle_like && ckpt_restore && slot_ok;
  assign save_ok    = idle_like && ckpt_save && !ckpt_restore;
  // Restore wins over the write issued in its request cycle.
  assign wr_ok      = wr_en && (wr_addr != '0) &&
                      idle_like && !restore_ok;
  // Any request that is not taken is reported.
  assign err_d      = (ckpt_restore && !restore_ok) ||
                      (ckpt_save && !save_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    unique case (state_q)
      RF_IDLE, RF_DONE: begin
        state_d = RF_IDLE;
        if (restore_ok) begin
          state_d = RF_COPY;
          cnt_d   = '0;
          slot_d  = ckpt_restore_slot;
        end
      end
      RF_COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BW'(NBLK - 1)) begin
          state_d = RF_DONE;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == RF_COPY);
    restore_done = (state_q == RF_DONE);
    ckpt_valid   = valid_q;
    ckpt_err     = err_q;
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx     = '0;
    regs_d  = regs_q;
    valid_d = valid_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
    if (state_q == RF_COPY) begin
      for (int j = 0; j < RPC; j++) begin
        idx = AW'(int'(cnt_q) * RPC + j);
        regs_d[idx] = blk_words[j*DW +: DW];
      end
    end
    if (save_ok && (int'(ckpt_save_slot) < NUM_CKPT)) begin
      valid_d[ckpt_save_slot] = 1'b1;
    end
    regs_d[0] = '0;
  end

  // Snapshot taken from the next-state view so a same-cycle write lands in it.
  always_comb begin
    save_row = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      save_row[i*DW +: DW] = regs_d[AW'(i)];
    end
  end

  ckpt_bank #(
    .DATA_WIDTH        (DATA_WIDTH),
    .NUM_REGS          (NUM_REGS),
    .NUM_CKPT          (NUM_CKPT),
    .RESTORE_PER_CYCLE (RESTORE_PER_CYCLE)
  ) u_bank (
    .clk       (clk),
    .save_en   (save_ok && !rst),
    .save_slot (ckpt_save_slot),
    .save_row  (save_row),
    .rd_slot   (slot_q),
    .rd_blk    (cnt_q),
    .rd_words  (blk_words)
  );

  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rv;
    ra      = '0;
    rv      = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rv = regs_q[ra];
`ifdef RF_WR_BYPASS_EN
      if (wr_ok && (wr_addr == ra)) begin
        rv = wr_data;
      end
`else
`endif
      if (!rd_en[i] || (ra == '0)) begin
        rv = '0;
      end
      rd_data[i*DW +: DW] = rv;
    end
  end

endmodule

// File: tb/tb_ckpt_reg_file.sv
// Self-checking bench for ckpt_reg_file (default parameters).
// Table-driven read/write vectors plus checkpoint corner-case sequences.
module tb_ckpt_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ckpt_save;
  logic [1:0]    ckpt_save_slot;
  logic          ckpt_restore;
  logic [1:0]    ckpt_restore_slot;
  logic [3:0]    ckpt_valid;
  logic          busy;
  logic          restore_done;
  logic          ckpt_err;

  ckpt_reg_file dut (
    .clk               (clk),
    .rst               (rst),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .ckpt_save         (ckpt_save),
    .ckpt_save_slot    (ckpt_save_slot),
    .ckpt_restore      (ckpt_restore),
    .ckpt_restore_slot (ckpt_restore_slot),
    .ckpt_valid        (ckpt_valid),
    .busy              (busy),
    .restore_done      (restore_done),
    .ckpt_err          (ckpt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t tbl [8];
  logic [DW-1:0] exp_q [$];
  int checks;
  int errors;
  int n;

  task automatic chk(input string nm,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic pop_chk(input string nm,
                         input logic [DW-1:0] got);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected <empty queue>", nm, got);
    end else begin
      e = exp_q.pop_front();
      chk(nm, got, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rd_en             = 2'b00;
    rd_addr           = '0;
    wr_en             = 1'b0;
    wr_addr           = '0;
    wr_data           = '0;
    ckpt_save         = 1'b0;
    ckpt_save_slot    = '0;
    ckpt_restore      = 1'b0;
    ckpt_restore_slot = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic wait_not_busy(input string nm);
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy stuck expected release", nm);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b11, 5'd1,  5'd0,
               32'h0, 32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'h1,        2'b11, 5'd5,  5'd0,
               32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd1,  32'hA5A5,     2'b01, 5'd5,  5'd5,
               32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 2'b11, 5'd1,  5'd0,
               32'hA5A5, 32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd1,
               32'hFFFFFFFF, 32'hA5A5};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd31, 5'd5,
               32'h0, 32'h0};
    tbl[6] = '{1'b1, 5'd2,  32'h1234,     2'b10, 5'd0,  5'd5,
               32'h0, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd2,  5'd31,
               32'h1234, 32'hFFFFFFFF};

    idle_in();
    rst = 1'b1;
    step();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, restore_done}, 32'h0);
    chk("rst_err", {31'b0, ckpt_err}, 32'h0);
    chk("rst_valid", {28'b0, ckpt_valid}, 32'h0);
    step();
    rst = 1'b0;
    rd(5'd5, 5'd31);
    chk("rst_r5", rd_data[DW-1:0], 32'h0);
    chk("rst_r31", rd_data[2*DW-1:DW], 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      rd_en   = tbl[i].re;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      exp_q.push_back(tbl[i].e0);
      exp_q.push_back(tbl[i].e1);
      #1;
      pop_chk($sformatf("vec%0d_p0", i), rd_data[DW-1:0]);
      pop_chk($sformatf("vec%0d_p1", i), rd_data[2*DW-1:DW]);
      step();
    end
    idle_in();

    // Save with same-cycle write, then restore.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
    step();
    wr_data = 32'h22; ckpt_save = 1'b1; ckpt_save_slot = 2'd2;
    step();
    idle_in();
    chk("save_valid", {28'b0, ckpt_valid}, 32'h4);
    chk("save_err", {31'b0, ckpt_err}, 32'h0);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    step();
    idle_in();
    rd(5'd3, 5'd0);
    chk("pre_rest_r3", rd_data[DW-1:0], 32'h33);
    ckpt_restore = 1'b1; ckpt_restore_slot = 2'd2;
    step();
    idle_in();
    chk("rest_busy", {31'b0, busy}, 32'h1);
    wait_not_busy("rest_wait");
    chk("rest_cycles", n, 32'd4);
    chk("rest_done", {31'b0, restore_done}, 32'h1);
    step();
    chk("rest_done_off", {31'b0, restore_done}, 32'h0);
    rd(5'd3, 5'd5);
    chk("rest_r3", rd_data[DW-1:0], 32'h22);
    chk("rest_r5", rd_data[2*DW-1:DW], 32'hDEADBEEF);
    chk("rest_valid", {28'b0, ckpt_valid}, 32'h4);

    // Restore of an invalid slot.
    ckpt_restore = 1'b1; ckpt_restore_slot = 2'd1;
    step();
    idle_in();
    chk("inv_err", {31'b0, ckpt_err}, 32'h1);
    chk("inv_busy", {31'b0, busy}, 32'h0);
    step();
    chk("inv_err_off", {31'b0, ckpt_err}, 32'h0);
    rd(5'd3, 5'd0);
    chk("inv_r3", rd_data[DW-1:0], 32'h22);

    // Requests while busy.
    ckpt_restore = 1'b1; ckpt_restore_slot = 2'd2;
    step();
    chk("bsy_busy", {31'b0, busy}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    ckpt_save = 1'b1; ckpt_save_slot = 2'd0;
    step();
    idle_in();
    chk("bsy_err", {31'b0, ckpt_err}, 32'h1);
    wait_not_busy("bsy_wait");
    rd(5'd7, 5'd3);
    chk("bsy_r7", rd_data[DW-1:0], 32'h0);
    chk("bsy_r3", rd_data[2*DW-1:DW], 32'h22);
    chk("bsy_valid", {28'b0, ckpt_valid}, 32'h4);

    // Same-cycle write and read.
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h44;
    step();
    wr_data = 32'h55;
    rd(5'd9, 5'd0);
`ifdef RF_WR_BYPASS_EN
    chk("byp_r9", rd_data[DW-1:0], 32'h55);
`else
    chk("byp_r9", rd_data[DW-1:0], 32'h44);
`endif
    step();
    idle_in();
    rd(5'd9, 5'd0);
    chk("byp_r9_after", rd_data[DW-1:0], 32'h55);

    // Reset in the middle of a restore.
    ckpt_restore = 1'b1; ckpt_restore_slot = 2'd2;
    step();
    idle_in();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_valid", {28'b0, ckpt_valid}, 32'h0);
    chk("mrst_done", {31'b0, restore_done}, 32'h0);
    rd(5'd3, 5'd9);
    chk("mrst_r3", rd_data[DW-1:0], 32'h0);
    chk("mrst_r9", rd_data[2*DW-1:DW], 32'h0);
    idle_in();
    ckpt_restore = 1'b1; ckpt_restore_slot = 2'd2;
    step();
    idle_in();
    chk("mrst_rej_err", {31'b0, ckpt_err}, 32'h1);
    chk("mrst_rej_busy", {31'b0, busy}, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
